// File: rtl/pc_redirect.sv
// Fetch PC selection with prediction, mispredict recovery and stall-deferred predictions.
// Latency: pc updates one cycle after its inputs; flushes and pcinc are combinational.
// Backpressure: stall holds pc (a predicted target is parked in one pending slot); any miss overrides stall.
module pc_redirect #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        jump_pred,
    input  logic [15:0] jump_pred_adr,
    input  logic        jump_pred_miss,
    input  logic [15:0] pcinc_evac,
    input  logic        jump_pred_adr_miss,
    input  logic [15:0] ALUres_mem,
    output logic [15:0] pc,
    output logic [15:0] pcinc,
    output logic        flush_if,
    output logic        flush_id,
    output logic        flush_ex,
    output logic [1:0]  redirect_state,
    output logic [7:0]  miss_count
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRED    = 2'd1,
        RECOVER = 2'd2
    } state_t;

    state_t      state;
    logic        pred_cnt;
    logic        pend_vld;
    logic [15:0] pend_adr;

    logic        miss;
    logic        pred_take;
    logic        pend_consume;
    logic        pred_direct;
    logic [15:0] pc_nxt;

    // A wrong target outranks a wrong direction when both resolve together.
    assign miss         = jump_pred_adr_miss | jump_pred_miss;
    // A new prediction is only accepted when nothing is parked and we are not recovering.
    assign pred_take    = jump_pred & ~miss & (state != RECOVER) & ~pend_vld;
    assign pend_consume = pend_vld & ~stall & ~miss;
    assign pred_direct  = pred_take & ~stall;

    assign pcinc          = pc + 16'd1;
    assign redirect_state = state;

    // Flushes are masked during reset so stray miss inputs cannot leak out.
    assign flush_if = ~reset & (miss | pend_consume | pred_direct);
    assign flush_id = ~reset & miss;
    assign flush_ex = ~reset & miss;

    // Next-PC mux in strict priority order.
    always_comb begin
        pc_nxt = pcinc;
        if (jump_pred_adr_miss)
            pc_nxt = ALUres_mem;
        else if (jump_pred_miss)
            pc_nxt = pcinc_evac;
        else if (stall)
            pc_nxt = pc;
        else if (pend_vld)
            pc_nxt = pend_adr;
        else if (pred_take)
            pc_nxt = jump_pred_adr;
    end

    // PC register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            pc <= RESET_PC;
        else
            pc <= pc_nxt;
    end

    // One-entry slot for a prediction that arrived while the front end was stalled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_vld <= 1'b0;
            pend_adr <= 16'h0000;
        end else if (miss || pend_consume) begin
            pend_vld <= 1'b0;
        end else if (pred_take && stall) begin
            pend_vld <= 1'b1;
            pend_adr <= jump_pred_adr;
        end
    end

    // Redirect FSM: PRED is a fixed 2-cycle window (restartable), RECOVER lasts one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            pred_cnt <= 1'b0;
        end else if (miss) begin
            state    <= RECOVER;
            pred_cnt <= 1'b0;
        end else if (pend_consume || pred_direct) begin
            state    <= PRED;
            pred_cnt <= 1'b0;
        end else begin
            case (state)
                PRED: begin
                    if (pred_cnt)
                        state <= IDLE;
                    pred_cnt <= ~pred_cnt;
                end
                default: begin
                    state    <= IDLE;
                    pred_cnt <= 1'b0;
                end
            endcase
        end
    end

    // Saturating count of miss cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            miss_count <= 8'h00;
        else if (miss && miss_count != 8'hFF)
            miss_count <= miss_count + 8'd1;
    end

endmodule

// File: tb/tb_pc_redirect.sv
// Self-checking bench for pc_redirect: directed scenarios plus a random phase against a behavioural model.
// Inputs change 1 time unit after each rising edge; flushes are sampled at the falling edge, registers after the edge.
// Expected results travel through a scoreboard queue from drive time to check time.
module tb_pc_redirect;

    localparam logic [15:0] RST_PC = 16'h0000;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        jump_pred;
    logic [15:0] jump_pred_adr;
    logic        jump_pred_miss;
    logic [15:0] pcinc_evac;
    logic        jump_pred_adr_miss;
    logic [15:0] ALUres_mem;
    logic [15:0] pc;
    logic [15:0] pcinc;
    logic        flush_if;
    logic        flush_id;
    logic        flush_ex;
    logic [1:0]  redirect_state;
    logic [7:0]  miss_count;

    pc_redirect #(.RESET_PC(RST_PC)) dut (
        .clk                (clk),
        .reset              (reset),
        .stall              (stall),
        .jump_pred          (jump_pred),
        .jump_pred_adr      (jump_pred_adr),
        .jump_pred_miss     (jump_pred_miss),
        .pcinc_evac         (pcinc_evac),
        .jump_pred_adr_miss (jump_pred_adr_miss),
        .ALUres_mem         (ALUres_mem),
        .pc                 (pc),
        .pcinc              (pcinc),
        .flush_if           (flush_if),
        .flush_id           (flush_id),
        .flush_ex           (flush_ex),
        .redirect_state     (redirect_state),
        .miss_count         (miss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        fi;
        logic        fid;
        logic        fex;
        logic [15:0] pc;
        logic [1:0]  st;
        logic [7:0]  mc;
    } exp_t;

    exp_t exp_q[$];

    int vectors = 0;
    int errors  = 0;

    // Reference model state.
    logic [15:0] m_pc;
    logic        m_pend_v;
    logic [15:0] m_pend_a;
    logic [1:0]  m_state;
    logic        m_cnt;
    logic [7:0]  m_mc;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc     = RST_PC;
        m_pend_v = 1'b0;
        m_pend_a = 16'h0000;
        m_state  = 2'd0;
        m_cnt    = 1'b0;
        m_mc     = 8'h00;
    endtask

    // Drive one cycle, predict its outcome, then check flushes and post-edge registers.
    task automatic apply(input logic st, input logic jp, input logic [15:0] jpa,
                         input logic pm, input logic [15:0] evac,
                         input logic am, input logic [15:0] alu);
        exp_t e;
        exp_t g;
        logic miss, take, cons, dir;
        stall = st; jump_pred = jp; jump_pred_adr = jpa;
        jump_pred_miss = pm; pcinc_evac = evac;
        jump_pred_adr_miss = am; ALUres_mem = alu;

        miss = am | pm;
        take = jp && !miss && (m_state != 2'd2) && !m_pend_v;
        cons = m_pend_v && !st && !miss;
        dir  = take && !st;
        e.fi  = miss | cons | dir;
        e.fid = miss;
        e.fex = miss;
        if (am)            e.pc = alu;
        else if (pm)       e.pc = evac;
        else if (st)       e.pc = m_pc;
        else if (m_pend_v) e.pc = m_pend_a;
        else if (take)     e.pc = jpa;
        else               e.pc = m_pc + 16'd1;

        if (miss || cons) m_pend_v = 1'b0;
        else if (take && st) begin m_pend_v = 1'b1; m_pend_a = jpa; end

        if (miss) m_state = 2'd2;
        else if (cons || dir) begin m_state = 2'd1; m_cnt = 1'b0; end
        else if (m_state == 2'd1) begin
            if (m_cnt) m_state = 2'd0;
            m_cnt = ~m_cnt;
        end else m_state = 2'd0;

        if (miss && m_mc != 8'hFF) m_mc = m_mc + 8'd1;
        e.st = m_state;
        e.mc = m_mc;
        m_pc = e.pc;
        exp_q.push_back(e);

        @(negedge clk);
        check_eq("flush_if", {31'd0, flush_if}, {31'd0, exp_q[0].fi});
        check_eq("flush_id", {31'd0, flush_id}, {31'd0, exp_q[0].fid});
        check_eq("flush_ex", {31'd0, flush_ex}, {31'd0, exp_q[0].fex});
        @(posedge clk);
        #1;
        g = exp_q.pop_front();
        check_eq("pc",        {16'd0, pc},    {16'd0, g.pc});
        check_eq("pcinc",     {16'd0, pcinc}, {16'd0, g.pc + 16'd1});
        check_eq("state",     {30'd0, redirect_state}, {30'd0, g.st});
        check_eq("miss_count",{24'd0, miss_count},     {24'd0, g.mc});
    endtask

    task automatic idle();
        apply(1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0);
    endtask

    initial begin
        reset = 1'b1;
        stall = 1'b0; jump_pred = 1'b0; jump_pred_adr = 16'h0;
        jump_pred_miss = 1'b0; pcinc_evac = 16'h0;
        jump_pred_adr_miss = 1'b0; ALUres_mem = 16'h0;
        model_reset();
        #3;
        check_eq("rst_pc",    {16'd0, pc},    {16'd0, RST_PC});
        check_eq("rst_pcinc", {16'd0, pcinc}, {16'd0, RST_PC + 16'd1});
        check_eq("rst_state", {30'd0, redirect_state}, 32'd0);
        check_eq("rst_mc",    {24'd0, miss_count},     32'd0);
        check_eq("rst_flush", {29'd0, flush_if, flush_id, flush_ex}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #3 reset = 1'b0;

        // Sequential fetch, then a prediction taken at pc=3.
        repeat (3) idle();
        check_eq("seq_pc3", {16'd0, pc}, 32'h3);
        apply(1'b0, 1'b1, 16'h0040, 1'b0, 16'h0, 1'b0, 16'h0);
        check_eq("pred_pc", {16'd0, pc}, 32'h40);
        repeat (3) idle();

        // Mispredict while stalled.
        apply(1'b1, 1'b0, 16'h0, 1'b1, 16'h0004, 1'b0, 16'h0);
        check_eq("evac_pc", {16'd0, pc}, 32'h4);
        check_eq("evac_mc", {24'd0, miss_count}, 32'h1);
        idle();

        // Both misses at once: target miss wins.
        apply(1'b0, 1'b0, 16'h0, 1'b1, 16'h0008, 1'b1, 16'h0100);
        check_eq("dual_pc", {16'd0, pc}, 32'h100);
        idle();

        // Prediction arriving under a 3-cycle stall is parked, then applied.
        repeat (3) apply(1'b1, 1'b1, 16'h0020, 1'b0, 16'h0, 1'b0, 16'h0);
        idle();
        check_eq("pend_pc", {16'd0, pc}, 32'h20);

        // Restart of the PRED window by a second prediction.
        apply(1'b0, 1'b1, 16'h0200, 1'b0, 16'h0, 1'b0, 16'h0);
        apply(1'b0, 1'b1, 16'h0300, 1'b0, 16'h0, 1'b0, 16'h0);
        repeat (3) idle();

        // Prediction during RECOVER is ignored.
        apply(1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 16'hFFFE);
        apply(1'b0, 1'b1, 16'h0500, 1'b0, 16'h0, 1'b0, 16'h0);
        check_eq("wrap_pre", {16'd0, pc}, 32'hFFFF);
        idle();
        check_eq("wrap_pc", {16'd0, pc}, 32'h0);

        // Miss counter saturation.
        for (int i = 0; i < 300; i++)
            apply(i[0], 1'b0, 16'h0, 1'b1, 16'h1000 + i[15:0], 1'b0, 16'h0);
        check_eq("sat_mc", {24'd0, miss_count}, 32'hFF);
        idle();

        // Random mix.
        for (int i = 0; i < 400; i++)
            apply($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, 16'($urandom),
                  $urandom_range(0, 9) == 0, 16'($urandom),
                  $urandom_range(0, 11) == 0, 16'($urandom));

        // Reset in the middle of RECOVER with a pending-capable stall.
        apply(1'b1, 1'b1, 16'h0777, 1'b1, 16'h0900, 1'b0, 16'h0);
        check_eq("recov_st", {30'd0, redirect_state}, 32'd2);
        #2 reset = 1'b1;
        #1;
        check_eq("mid_rst_pc",    {16'd0, pc}, {16'd0, RST_PC});
        check_eq("mid_rst_state", {30'd0, redirect_state}, 32'd0);
        check_eq("mid_rst_mc",    {24'd0, miss_count}, 32'd0);
        check_eq("mid_rst_flush", {29'd0, flush_if, flush_id, flush_ex}, 32'd0);
        @(posedge clk);
        #3 reset = 1'b0;
        model_reset();
        idle();
        check_eq("post_rst_pc", {16'd0, pc}, {16'd0, RST_PC + 16'd1});
        repeat (3) idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/pc_redirect.md
PC_REDIRECT -- requirements
Module: pc_redirect

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'h0000, meaning the PC value loaded on reset.
REQ-002 SHALL have port clk  input  1  meaning the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  meaning reset, asynchronous and active-high.
REQ-004 SHALL have port stall  input  1  meaning hold PC this cycle (pipeline hazard).
REQ-005 SHALL have port jump_pred  input  1  meaning predicted-taken jump in ID this cycle.
REQ-006 SHALL have port jump_pred_adr  input  16  meaning predicted target, valid with jump_pred.
REQ-007 SHALL have port jump_pred_miss  input  1  meaning a taken prediction resolved not-taken.
REQ-008 SHALL have port pcinc_evac  input  16  meaning the saved fall-through address, valid with jump_pred_miss.
REQ-009 SHALL have port jump_pred_adr_miss  input  1  meaning a real jump with wrong or absent prediction.
REQ-010 SHALL have port ALUres_mem  input  16  meaning the resolved jump target, valid with jump_pred_adr_miss.
REQ-011 SHALL have port pc  output  16  meaning the current fetch address.
REQ-012 SHALL have port pcinc  output  16  meaning pc+1, mod 2^16.
REQ-013 SHALL have ports flush_if, flush_id, flush_ex  output  1 each  meaning squash that stage's instruction this cycle.
REQ-014 SHALL have port redirect_state  output  2  meaning FSM state: 0 IDLE, 1 PRED, 2 RECOVER.
REQ-015 SHALL have port miss_count  output  8  meaning saturating count of miss redirects.

Function
REQ-016 SHALL select next PC by strict priority: adr_miss -> ALUres_mem; pred_miss -> pcinc_evac; stall -> hold pc; pending prediction -> pend_adr; jump_pred (accepted) -> jump_pred_adr; else pcinc.
REQ-017 SHALL treat jump_pred_adr_miss and jump_pred_miss asserted together as adr_miss only.
REQ-018 SHALL override stall with any miss: the redirect occurs even when stall=1.
REQ-019 SHALL, on a miss cycle, assert flush_if, flush_id and flush_ex combinationally in that same cycle.
REQ-020 SHALL, on an accepted, unstalled jump_pred cycle, assert flush_if only in that same cycle.
REQ-021 SHALL ignore jump_pred while in RECOVER or when a miss is asserted in the same cycle.
REQ-022 SHALL, on jump_pred with stall=1 and no miss, latch jump_pred_adr into a one-entry pending register.
REQ-023 SHALL, with the pending register valid, ignore further jump_pred until the pending register is consumed.
REQ-024 SHALL consume the pending register on the first non-stall cycle: PC is loaded with pend_adr and flush_if is asserted.
REQ-025 SHALL clear the pending register on any miss.
REQ-026 FSM transitions SHALL be:
- IDLE -> PRED on an applied prediction (direct or pending).
- PRED holds for exactly 2 cycles, regardless of stall, then -> IDLE.
- Any state -> RECOVER on a miss.
- RECOVER -> IDLE after 1 cycle.
REQ-027 SHALL, in PRED, restart the 2-cycle window when a new prediction is applied.
REQ-028 SHALL increment miss_count by 1 per miss cycle and saturate at 8'hFF.
REQ-029 SHALL keep pcinc combinational from pc, wrapping 16'hFFFF to 16'h0000.
REQ-030 SHALL drive flush_if, flush_id and flush_ex to 0 in every cycle not covered by REQ-019, REQ-020 or REQ-024.

Reset
REQ-031 SHALL, while reset=1 and independent of clk, force:
- pc=RESET_PC, pcinc=RESET_PC+1;
- redirect_state=IDLE;
- pending register invalid;
- miss_count=0;
- all flush outputs 0.
REQ-032 SHALL abandon any in-flight PRED, RECOVER or pending state on reset asserted mid-operation, with no redirect after release.
REQ-033 SHALL, on the first rising edge after reset deasserts with no other input, load pc=RESET_PC+1.

Verification
REQ-034 Sequential run: RESET_PC=0, 4 idle cycles -> pc 1,2,3,4; flushes 0; state IDLE.
REQ-035 Prediction applied: jump_pred=1, jump_pred_adr=16'h0040 at pc=3 -> flush_if=1 that cycle; next pc=16'h0040; state PRED for 2 cycles then IDLE.
REQ-036 Mispredict under stall: stall=1, jump_pred_miss=1, pcinc_evac=16'h0004 -> flush_if, flush_id, flush_ex=1; next pc=16'h0004; state RECOVER then IDLE; miss_count=1.
REQ-037 Simultaneous misses: adr_miss=1, ALUres_mem=16'h0100, pred_miss=1, pcinc_evac=16'h0008 -> next pc=16'h0100; miss_count +1.
REQ-038 Pending prediction: jump_pred=1, adr=16'h0020 with stall=1 for 3 cycles -> pc held, no flush; first unstalled cycle flush_if=1, then pc=16'h0020.
REQ-039 Edge cases:
- pc=16'hFFFF idle -> pc=16'h0000.
- 300 misses -> miss_count=8'hFF.
- reset mid-RECOVER -> pc=RESET_PC immediately.
